// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller: FSM state encoding
// and parameter defaults used by hazard_stall_ctrl and hazard_detect.
package hazard_stall_ctrl_pkg;

  // Controller states
  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_DRAIN  = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;

  // Parameter defaults
  localparam int HSC_BITS_REGS_DEF    = 5;
  localparam int HSC_DRAIN_CYCLES_DEF = 3;
  localparam int HSC_CNT_BITS_DEF     = 16;

  // Width of a down-counter that must hold values 0 .. n-1 (minimum 1 bit)
  function automatic int drain_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: purely combinational load-use comparator. Flags a stall
// when a load in EX writes a register read in ID, or when a load in MEM
// writes the base register of a JALR/JR sitting in ID.
module hazard_detect
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int BITS_REGS = HSC_BITS_REGS_DEF
) (
  input  logic                 i_IDEX_MemRead,
  input  logic                 i_EXMEM_MemRead,
  input  logic                 i_JALR,
  input  logic [BITS_REGS-1:0] i_IDEX_Rt,
  input  logic [BITS_REGS-1:0] i_EXMEM_Rt,
  input  logic [BITS_REGS-1:0] i_IFID_Rs,
  input  logic [BITS_REGS-1:0] i_IFID_Rt,
  output logic                 o_hazard
);

  logic w_ex_load_use;
  logic w_mem_jalr_use;

  // Compare producer destinations against consumer sources
  always_comb begin
    w_ex_load_use  = i_IDEX_MemRead &
                     ((i_IDEX_Rt == i_IFID_Rs) | (i_IDEX_Rt == i_IFID_Rt));
    w_mem_jalr_use = i_EXMEM_MemRead & i_JALR & (i_EXMEM_Rt == i_IFID_Rs);
    o_hazard       = w_ex_load_use | w_mem_jalr_use;
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush/halt controller.
// RUN handles memory hold, branch flush and load-use bubbles; a HALT in ID
// drains the pipe for DRAIN_CYCLES before entering the sticky HALTED state.
// Optional feature: define HAZARD_STALL_CNT_EN to build the saturating
// stall-cycle counter on o_stall_cnt (otherwise it is tied to zero).
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int BITS_REGS    = HSC_BITS_REGS_DEF,
  parameter int DRAIN_CYCLES = HSC_DRAIN_CYCLES_DEF,
  parameter int CNT_BITS     = HSC_CNT_BITS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_EXMEM_Flush,
  input  logic                 i_IDEX_MemRead,
  input  logic                 i_EXMEM_MemRead,
  input  logic                 i_JALR,
  input  logic                 i_HALT,
  input  logic                 i_mem_busy,
  input  logic [BITS_REGS-1:0] i_IDEX_Rt,
  input  logic [BITS_REGS-1:0] i_EXMEM_Rt,
  input  logic [BITS_REGS-1:0] i_IFID_Rs,
  input  logic [BITS_REGS-1:0] i_IFID_Rt,
  output logic                 o_Mux_Risk,
  output logic                 o_pc_Write,
  output logic                 o_IFID_Write,
  output logic                 o_pipe_hold,
  output logic                 o_Latch_Flush,
  output logic                 o_halted,
  output logic [CNT_BITS-1:0]  o_stall_cnt
);

  localparam int DCW = drain_cnt_width(DRAIN_CYCLES);

  logic [1:0]     r_state;
  logic [DCW-1:0] r_drain_cnt;
  logic           r_flush_pend;

  logic [1:0]     w_next_state;
  logic [DCW-1:0] w_next_cnt;
  logic           w_next_pend;
  logic           w_hazard;
  logic           w_flush_req;
  logic           w_pc_write;
  logic           w_ifid_write;
  logic           w_mux_risk;
  logic           w_pipe_hold;
  logic           w_latch_flush;
  logic           w_halted;

  hazard_detect #(
    .BITS_REGS (BITS_REGS)
  ) u_hazard_detect (
    .i_IDEX_MemRead  (i_IDEX_MemRead),
    .i_EXMEM_MemRead (i_EXMEM_MemRead),
    .i_JALR          (i_JALR),
    .i_IDEX_Rt       (i_IDEX_Rt),
    .i_EXMEM_Rt      (i_EXMEM_Rt),
    .i_IFID_Rs       (i_IFID_Rs),
    .i_IFID_Rt       (i_IFID_Rt),
    .o_hazard        (w_hazard)
  );

  // A flush seen while memory was busy is remembered and replayed once it frees up
  assign w_flush_req = i_EXMEM_Flush | r_flush_pend;

  // Output decode and next-state logic
  always_comb begin
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_mux_risk    = 1'b0;
    w_pipe_hold   = 1'b0;
    w_latch_flush = 1'b0;
    w_halted      = 1'b0;
    w_next_state  = r_state;
    w_next_cnt    = r_drain_cnt;
    w_next_pend   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_mem_busy) begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_pipe_hold  = 1'b1;
          w_next_pend  = w_flush_req;
        end else if (w_flush_req) begin
          w_latch_flush = 1'b1;
        end else if (w_hazard) begin
          w_mux_risk   = 1'b1;
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
        end else if (i_HALT) begin
          w_pc_write = 1'b0;
          w_next_cnt = DCW'(DRAIN_CYCLES - 1);
          // With a single drain cycle the counter starts at zero: halt directly
          if (DRAIN_CYCLES <= 1) begin
            w_next_state = ST_HALTED;
          end else begin
            w_next_state = ST_DRAIN;
          end
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (i_mem_busy) begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_pipe_hold  = 1'b1;
          w_next_pend  = w_flush_req;
        end else if (w_flush_req) begin
          // HALT was on the wrong path: resume fetching
          w_latch_flush = 1'b1;
          w_next_state  = ST_RUN;
          w_next_cnt    = {DCW{1'b0}};
        end else begin
          w_pc_write = 1'b0;
          if (r_drain_cnt <= DCW'(1)) begin
            w_next_state = ST_HALTED;
            w_next_cnt   = {DCW{1'b0}};
          end else begin
            w_next_cnt = r_drain_cnt - DCW'(1);
          end
        end
      end
      ST_HALTED: begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_pipe_hold  = 1'b1;
        w_halted     = 1'b1;
      end
      default: begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_pipe_hold  = 1'b1;
        w_next_state = ST_RUN;
        w_next_cnt   = {DCW{1'b0}};
      end
    endcase
  end

  // State, drain counter and deferred-flush registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_RUN;
      r_drain_cnt  <= {DCW{1'b0}};
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_drain_cnt  <= w_next_cnt;
      r_flush_pend <= w_next_pend;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_BITS-1:0] r_stall_cnt;

  // Saturating count of cycles where the PC is held, excluding HALTED
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stall_cnt <= {CNT_BITS{1'b0}};
    end else if ((r_state != ST_HALTED) && !w_pc_write &&
                 (r_stall_cnt != {CNT_BITS{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_BITS'(1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = {CNT_BITS{1'b0}};
`endif

  assign o_Mux_Risk    = w_mux_risk;
  assign o_pc_Write    = w_pc_write;
  assign o_IFID_Write  = w_ifid_write;
  assign o_pipe_hold   = w_pipe_hold;
  assign o_Latch_Flush = w_latch_flush;
  assign o_halted      = w_halted;

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameters SHALL be: BITS_REGS, default 5, register-index width; DRAIN_CYCLES, default 3, cycles from HALT detection to halted; CNT_BITS, default 16, stall-counter width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- i_clk, in, 1, single clock; all state on rising edge.
- i_reset_n, in, 1, asynchronous active-low reset.
- i_EXMEM_Flush, in, 1, taken branch/jump resolved in MEM.
- i_IDEX_MemRead, in, 1, load in EX.
- i_EXMEM_MemRead, in, 1, load in MEM.
- i_JALR, in, 1, JALR/JR in ID.
- i_HALT, in, 1, HALT in ID.
- i_mem_busy, in, 1, data memory not ready; whole pipe must hold.
- i_IDEX_Rt, i_EXMEM_Rt, i_IFID_Rs, i_IFID_Rt, in, BITS_REGS, hazard register indices.
- o_Mux_Risk, out, 1, insert bubble into ID/EX.
- o_pc_Write, out, 1, PC update enable.
- o_IFID_Write, out, 1, IF/ID latch enable.
- o_pipe_hold, out, 1, freeze ID/EX, EX/MEM, MEM/WB.
- o_Latch_Flush, out, 1, flush IF/ID and ID/EX.
- o_halted, out, 1, processor halted, sticky.
- o_stall_cnt, out, CNT_BITS, stall-cycle count (macro-dependent, see REQ-017).

Function
REQ-003 States SHALL be RUN, DRAIN, HALTED; outputs SHALL be combinational from state and inputs.
REQ-004 Load-use hazard SHALL be (i_IDEX_MemRead and i_IDEX_Rt equal to i_IFID_Rs or i_IFID_Rt) or (i_EXMEM_MemRead and i_EXMEM_Rt equals i_IFID_Rs and i_JALR).
REQ-005 In RUN, priority SHALL be: i_mem_busy, then i_EXMEM_Flush, then hazard, then i_HALT, then normal.
REQ-006 In RUN with i_mem_busy: o_pc_Write=0, o_IFID_Write=0, o_pipe_hold=1, o_Mux_Risk=0, o_Latch_Flush=0; a pending flush is deferred until i_mem_busy falls.
REQ-007 In RUN with flush (no busy): o_Latch_Flush=1, o_pc_Write=1, o_IFID_Write=1, o_Mux_Risk=0; a coincident hazard or HALT is ignored.
REQ-008 In RUN with hazard only: o_Mux_Risk=1, o_pc_Write=0, o_IFID_Write=0 for that cycle; bubble count per hazard instance is 1.
REQ-009 In RUN with i_HALT only: o_pc_Write=0, o_IFID_Write=1; next state DRAIN; drain counter loads DRAIN_CYCLES-1.
REQ-010 In DRAIN: o_pc_Write=0, o_IFID_Write=1; counter decrements per cycle not held by i_mem_busy; i_mem_busy applies REQ-006 outputs and freezes the counter.
REQ-011 In DRAIN with i_EXMEM_Flush (no busy): o_Latch_Flush=1, o_pc_Write=1, next state RUN, because the HALT was wrong-path.
REQ-012 DRAIN SHALL go to HALTED when the counter is 0 and no flush or busy is present; with DRAIN_CYCLES=1, HALTED is reached one cycle after i_HALT.
REQ-013 In HALTED: o_halted=1, o_pc_Write=0, o_IFID_Write=0, o_pipe_hold=1; all inputs are ignored until reset.
REQ-014 Normal outputs SHALL be o_pc_Write=1, o_IFID_Write=1, all others 0.

Reset
REQ-015 Asserting i_reset_n low SHALL immediately force RUN, drain counter 0, and stall counter 0, including mid-DRAIN or HALTED; combinational outputs then follow RUN rules.
REQ-016 Reset release SHALL take effect on the first rising i_clk edge after i_reset_n goes high.

Configuration
REQ-017 Macro HAZARD_STALL_CNT_EN defined: o_stall_cnt SHALL increment, saturating at all-ones, on every cycle with o_pc_Write=0 outside HALTED. Undefined: o_stall_cnt SHALL be constant 0 and no counter flops are built.

Structure
REQ-018 The state encoding (RUN=2'b00, DRAIN=2'b01, HALTED=2'b10) and parameter defaults SHALL live in the shared hazard package.
REQ-019 The REQ-004 comparator logic SHALL be one combinational sub-module, hazard_detect; the FSM and counters stay in the top.

Verification
REQ-020 Bench SHALL cover the following scenarios:
- Load-use: IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5 for one cycle -> Mux_Risk=1, pc_Write=0, IFID_Write=0 that cycle only.
- JALR: EXMEM_MemRead=1, EXMEM_Rt=7, IFID_Rs=7, JALR=1 -> stall; same inputs with JALR=0 -> no stall.
- Flush plus hazard in the same cycle -> Latch_Flush=1, Mux_Risk=0, pc_Write=1.
- HALT with DRAIN_CYCLES=3 -> o_halted=1 exactly 3 edges later and stays 1; flush at DRAIN cycle 2 -> return to RUN, o_halted never 1.
- mem_busy held 4 cycles during DRAIN -> HALTED delayed by 4 cycles; pipe_hold=1 throughout.
- Reset pulse while HALTED -> o_halted=0 immediately; with macro defined, stall_cnt=0, then counts 3 after 3 stall cycles.
